nmos_phase_gen: RTL and testbench
=================================

# nmos_phase_gen

Two-phase, non-overlapping clock sequencer for the NMOS simulation library. It derives the PHI1/PHI2 qualifiers (C1/C2) from the single simulation clock that every NMOS_* register samples on. It supports free-run and single-step modes, with phase and dead-time lengths programmable at run time. It is the block the testbench clock generator hierarchy exposes as the source of `main_clk`-qualified phases.

## Interface
- PHASE_W, 8: width of phase/gap length fields
- CNT_W, 32: width of the completed-cycle counter
- main_clk  in  1  simulation clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  level; free-run request
- step_req  in  1  level; single-cycle step request, held until step_ack
- step_ack  out  1  one-cycle pulse when a step cycle completes
- ph1_len  in  PHASE_W  C1 high time in main_clk cycles (0 treated as 1)
- ph2_len  in  PHASE_W  C2 high time in main_clk cycles (0 treated as 1)
- gap_len  in  PHASE_W  dead time between phases (0 = no dead cycle)
- C1  out  1  PHI1 qualifier, registered
- C2  out  1  PHI2 qualifier, registered
- busy  out  1  high whenever state ≠ IDLE
- cyc_cnt  out  CNT_W  completed PHI1/PHI2 cycles, wraps modulo 2^CNT_W

## Operation
- Reset values: state IDLE, C1=0, C2=0, step_ack=0, busy=0, cyc_cnt=0, timer=0.
- States: IDLE, PH1, GAP12, PH2, GAP21.
- IDLE → PH1 when run=1, or when step_req=1 and run=0 (step mode latched). If run and step_req are both high, run wins; step_req stays pending and gets no ack.
- On entry to PH1, latch ph1_len/ph2_len/gap_len into shadow registers. Input changes mid-cycle take effect at the next PH1 entry only.
- PH1 lasts max(ph1_len,1) cycles → GAP12.
- GAP12 lasts gap_len cycles → PH2. If gap_len=0, PH1 goes directly to PH2.
- PH2 lasts max(ph2_len,1) cycles → GAP21, or directly to end-of-cycle if gap_len=0.
- End of cycle (last cycle of GAP21/PH2):
  - cyc_cnt increments.
  - If run=1 and not in step mode → PH1.
  - Otherwise → IDLE. If in step mode, pulse step_ack for one cycle and clear step mode.
- run deasserted mid-cycle: the current cycle completes in full; phases are never truncated.
- C1 = (state==PH1), C2 = (state==PH2), both registered. C1&C2 is never 1, including during reset and the gap_len=0 case.
- step_req must drop after step_ack. A step_req still high in IDLE with run=0 starts another step.
- rst mid-cycle: return to IDLE at the next edge, C1/C2 low that edge, shadow lengths and step mode cleared.

## Timing
- run sampled high at edge N in IDLE → C1=1 after edge N+1.
- Period = max(ph1_len,1) + max(ph2_len,1) + 2·gap_len cycles.
- Per-cycle sequence: C1 high for ph1 cycles, then gap_len cycles both low, then C2 high for ph2 cycles, then gap_len cycles both low.
- step_ack asserts on the same edge that busy falls.
- cyc_cnt updates on the edge leaving the last cycle of a period; it wraps from all-ones to 0.
- No combinational path from any input to C1/C2.

## Structure
- Package nmos_clk_pkg holds:
  - the state enum (IDLE, PH1, GAP12, PH2, GAP21);
  - default PHASE_W and CNT_W;
  - a helper function returning max(len,1).
- Sub-module nmos_phase_timer: loadable PHASE_W down-counter with load value, load strobe and a `last` flag (count==1 or loaded with 0/1). The FSM uses one instance for all states.
- The top level holds the FSM, shadow registers, step-mode flag and cycle counter.

## Test plan
- Reset then run=1, ph1=2, ph2=3, gap=1 → C1 high 2 cycles, low 1, C2 high 3, low 1; period 7; cyc_cnt 1,2,3 at 7-cycle spacing.
- gap=0, ph1=ph2=1 → C1/C2 alternate every cycle; assert C1&C2 never 1 across 1000 cycles.
- run=0, step_req held → exactly one period, then step_ack 1-cycle pulse with busy falling on the same edge; cyc_cnt=1; C1/C2 stay low afterwards until step_req drops and rises again.
- ph1_len changed 2→5 during PH2 → the current period is unchanged; the next period has C1 high 5 cycles.
- run dropped during PH1 → PH1, GAP12, PH2, GAP21 all complete, then IDLE; cyc_cnt +1.
- rst during PH2, then preload cyc_cnt to 2^CNT_W−1 via force and run one period → reset gives C1=C2=0, busy=0 next edge; cyc_cnt wraps to 0.

Source files
------------

// File: rtl/nmos_clk_pkg.sv
// Shared types and defaults for the NMOS two-phase clock sequencer.
package nmos_clk_pkg;

   localparam int unsigned DefPhaseW = 8;
   localparam int unsigned DefCntW   = 32;

   typedef enum logic [2:0] {
      StIdle,
      StPh1,
      StGap12,
      StPh2,
      StGap21
   } phase_state_e;

   // A programmed phase length of zero still yields one active cycle.
   function automatic int unsigned len_min1(input int unsigned len);
      return (len == 0) ? 1 : len;
   endfunction

endpackage

// File: rtl/nmos_phase_timer.sv
// Loadable down-counter timing the dwell of each sequencer state.
module nmos_phase_timer
   import nmos_clk_pkg::*;
#(
   parameter int unsigned PHASE_W = DefPhaseW
) (
   input  logic               main_clk,
   input  logic               rst,
   input  logic               load,
   input  logic [PHASE_W-1:0] load_val,
   output logic               last
);

   logic [PHASE_W-1:0] count_q;

   always_ff @(posedge main_clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - PHASE_W'(1);
      end
   end

   assign last = (count_q == '0) || (count_q == PHASE_W'(1));

endmodule

// File: rtl/nmos_phase_gen.sv
// Two-phase non-overlapping C1/C2 sequencer with free-run and single-step modes.
module nmos_phase_gen
   import nmos_clk_pkg::*;
#(
   parameter int unsigned PHASE_W = DefPhaseW,
   parameter int unsigned CNT_W   = DefCntW
) (
   input  logic               main_clk,
   input  logic               rst,
   input  logic               run,
   input  logic               step_req,
   output logic               step_ack,
   input  logic [PHASE_W-1:0] ph1_len,
   input  logic [PHASE_W-1:0] ph2_len,
   input  logic [PHASE_W-1:0] gap_len,
   output logic               C1,
   output logic               C2,
   output logic               busy,
   output logic [CNT_W-1:0]   cyc_cnt
);

   phase_state_e       state_q, state_d;
   logic [PHASE_W-1:0] ph2_sh_q, gap_sh_q;
   logic [CNT_W-1:0]   cyc_cnt_q;
   logic               step_mode_q;
   logic               timer_load, timer_last;
   logic [PHASE_W-1:0] timer_val;
   logic               end_cyc, start, start_step;

   nmos_phase_timer #(
      .PHASE_W (PHASE_W)
   ) u_timer (
      .main_clk (main_clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .last     (timer_last)
   );

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      timer_val  = '0;
      end_cyc    = 1'b0;
      start      = 1'b0;
      start_step = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               start = 1'b1;
            end else if (step_req) begin
               start      = 1'b1;
               start_step = 1'b1;
            end
         end
         StPh1: begin
            if (timer_last) begin
               timer_load = 1'b1;
               if (gap_sh_q != '0) begin
                  state_d   = StGap12;
                  timer_val = gap_sh_q;
               end else begin
                  state_d   = StPh2;
                  timer_val = ph2_sh_q;
               end
            end
         end
         StGap12: begin
            if (timer_last) begin
               state_d    = StPh2;
               timer_load = 1'b1;
               timer_val  = ph2_sh_q;
            end
         end
         StPh2: begin
            if (timer_last) begin
               if (gap_sh_q != '0) begin
                  state_d    = StGap21;
                  timer_load = 1'b1;
                  timer_val  = gap_sh_q;
               end else begin
                  end_cyc = 1'b1;
               end
            end
         end
         StGap21: begin
            if (timer_last) end_cyc = 1'b1;
         end
         default: state_d = StIdle;
      endcase
      if (end_cyc) begin
         if (run && !step_mode_q) start = 1'b1;
         else                     state_d = StIdle;
      end
      // PH1 length is consumed straight into the timer, so it needs no shadow copy.
      if (start) begin
         state_d    = StPh1;
         timer_load = 1'b1;
         timer_val  = PHASE_W'(len_min1(32'(ph1_len)));
      end
   end

   always_ff @(posedge main_clk) begin
      if (rst) begin
         state_q     <= StIdle;
         C1          <= 1'b0;
         C2          <= 1'b0;
         step_ack    <= 1'b0;
         cyc_cnt_q   <= '0;
         step_mode_q <= 1'b0;
         ph2_sh_q    <= '0;
         gap_sh_q    <= '0;
      end else begin
         state_q  <= state_d;
         C1       <= (state_q == StPh1);
         C2       <= (state_q == StPh2);
         step_ack <= end_cyc && step_mode_q;
         if (end_cyc) begin
            cyc_cnt_q   <= cyc_cnt_q + CNT_W'(1);
            step_mode_q <= 1'b0;
         end
         if (start) begin
            step_mode_q <= start_step;
            ph2_sh_q    <= PHASE_W'(len_min1(32'(ph2_len)));
            gap_sh_q    <= gap_len;
         end
      end
   end

   assign busy    = (state_q != StIdle);
   assign cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_nmos_phase_gen.sv
// Randomised and directed bench for nmos_phase_gen against a period-position model.
module tb_nmos_phase_gen;

   localparam int unsigned PW = 8;
   localparam int unsigned CW = 32;

   logic          main_clk = 1'b0;
   logic          rst, run, step_req;
   logic          step_ack, C1, C2, busy;
   logic [PW-1:0] ph1_len, ph2_len, gap_len;
   logic [CW-1:0] cyc_cnt;

   nmos_phase_gen #(
      .PHASE_W (PW),
      .CNT_W   (CW)
   ) dut (
      .main_clk (main_clk),
      .rst      (rst),
      .run      (run),
      .step_req (step_req),
      .step_ack (step_ack),
      .ph1_len  (ph1_len),
      .ph2_len  (ph2_len),
      .gap_len  (gap_len),
      .C1       (C1),
      .C2       (C2),
      .busy     (busy),
      .cyc_cnt  (cyc_cnt)
   );

   always #5 main_clk = ~main_clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Model: a period is a position counter 0..per-1 split by arithmetic into
   // PH1 | gap | PH2 | gap; C1/C2 reflect the position held before each edge.
   bit          m_active, m_step, m_ack, m_c1, m_c2;
   int          m_pos, m_p1, m_p2, m_g;
   logic [31:0] m_cnt;

   function automatic int clamp1(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_start(input bit s);
      m_active = 1'b1;
      m_pos    = 0;
      m_step   = s;
      m_p1     = clamp1(int'(ph1_len));
      m_p2     = clamp1(int'(ph2_len));
      m_g      = int'(gap_len);
   endtask

   always @(posedge main_clk) begin
      if (rst) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_step   = 1'b0;
         m_cnt    = '0;
         m_ack    = 1'b0;
         m_c1     = 1'b0;
         m_c2     = 1'b0;
      end else begin
         m_c1  = m_active && (m_pos < m_p1);
         m_c2  = m_active && (m_pos >= m_p1 + m_g) && (m_pos < m_p1 + m_g + m_p2);
         m_ack = 1'b0;
         if (!m_active) begin
            if (run)           model_start(1'b0);
            else if (step_req) model_start(1'b1);
         end else if (m_pos == m_p1 + m_p2 + 2 * m_g - 1) begin
            m_cnt = m_cnt + 32'd1;
            if (run && !m_step) begin
               model_start(1'b0);
            end else begin
               m_active = 1'b0;
               m_ack    = m_step;
               m_step   = 1'b0;
            end
         end else begin
            m_pos++;
         end
      end
   end

   always @(negedge main_clk) begin
      if (chk_en) begin
         check_val("c1", 32'(C1), 32'(m_c1));
         check_val("c2", 32'(C2), 32'(m_c2));
         check_val("busy", 32'(busy), 32'(m_active));
         check_val("step_ack", 32'(step_ack), 32'(m_ack));
         check_val("cyc_cnt", cyc_cnt, m_cnt);
         check_val("no_overlap", 32'(C1 & C2), 32'd0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge main_clk);
   endtask

   task automatic set_len(input int a, input int b, input int g);
      ph1_len = PW'(a);
      ph2_len = PW'(b);
      gap_len = PW'(g);
   endtask

   initial begin
      bit seen;
      rst      = 1'b1;
      run      = 1'b0;
      step_req = 1'b0;
      set_len(0, 0, 0);
      @(negedge main_clk);
      chk_en = 1'b1;
      cyc(1);
      check_val("rst_c1", 32'(C1), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_cnt", cyc_cnt, 32'd0);

      // Free run 2/3/1: period 7.
      rst = 1'b0;
      set_len(2, 3, 1);
      run = 1'b1;
      cyc(30);
      run = 1'b0;
      cyc(10);

      // Tightest alternation, no dead cycles.
      set_len(1, 1, 0);
      run = 1'b1;
      cyc(1000);
      run = 1'b0;
      cyc(5);

      // Single step from a fresh reset.
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      set_len(2, 3, 1);
      step_req = 1'b1;
      seen     = 1'b0;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         if (m_ack) begin
            seen = step_ack;
            break;
         end
      end
      check_val("step_ack_seen", 32'(seen), 32'd1);
      check_val("step_cnt", cyc_cnt, 32'd1);
      check_val("step_busy_low", 32'(busy), 32'd0);
      step_req = 1'b0;
      cyc(8);
      check_val("step_idle_c1", 32'(C1), 32'd0);

      // ph1_len change mid-period only affects the next period.
      run = 1'b1;
      cyc(4);
      ph1_len = PW'(5);
      cyc(20);
      run = 1'b0;
      cyc(20);

      // run dropped in PH1: period still completes.
      run = 1'b1;
      cyc(1);
      run = 1'b0;
      cyc(15);

      // Reset mid-period, then counter wrap.
      set_len(2, 3, 1);
      run = 1'b1;
      cyc(5);
      rst = 1'b1;
      cyc(1);
      check_val("midrst_c1", 32'(C1), 32'd0);
      check_val("midrst_c2", 32'(C2), 32'd0);
      check_val("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      run = 1'b0;
      cyc(2);
      #2;
      force dut.cyc_cnt_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cyc_cnt_q;
      cyc(1);
      run = 1'b1;
      cyc(1);
      run = 1'b0;
      cyc(12);
      check_val("wrap", cyc_cnt, 32'd0);

      // Random traffic.
      for (int it = 0; it < 3000; it++) begin
         int r;
         cyc(1);
         if (m_ack) step_req = 1'b0;
         r   = int'($urandom_range(0, 99));
         rst = (r == 50);
         if (r < 3) set_len(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                            int'($urandom_range(0, 3)));
         else if (r < 6) run = ~run;
         else if (r < 9 && !run && !step_req) step_req = 1'b1;
      end
      run      = 1'b0;
      step_req = 1'b0;
      rst      = 1'b0;
      cyc(30);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
